// File: rtl/driver_userkey_db.sv
// driver_userkey_db: synchronises, debounces and edge-detects NKEYS push-buttons
// and exposes them on a small CPU-bridge register set with one level interrupt.
//
// Ports:
//   sys_clk   system clock, rising edge
//   sys_rstn  asynchronous active-low reset
//   user_key  raw asynchronous key pads (NKEYS wide)
//   addr      word select: 0 LEVEL, 1 PRESS (W1C), 2 MASK, 3 RELEASE/reserved
//   WE, WD    write strobe and write data for the selected register
//   RD        read data, combinational from addr, forced to 0 during reset
//   irq       registered level interrupt request
//
// Optional feature macro: USERKEY_RELEASE_EN adds a sticky W1C RELEASE register
// at addr 3 and folds it into irq. Without it addr 3 reads 0 and ignores writes.
//
// Parameter legal ranges: NKEYS 1..32, DB_CYCLES >= 2.

module driver_userkey_db #(
    parameter int unsigned NKEYS      = 8,
    parameter int unsigned DB_CYCLES  = 20000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic [NKEYS-1:0] user_key,
    input  logic [1:0]       addr,
    input  logic             WE,
    input  logic [31:0]      WD,
    output logic [31:0]      RD,
    output logic             irq
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    localparam logic [1:0] A_LEVEL   = 2'd0;
    localparam logic [1:0] A_PRESS   = 2'd1;
    localparam logic [1:0] A_MASK    = 2'd2;
    localparam logic [1:0] A_RELEASE = 2'd3;

    // Polarity correction: k_n is 1 while a key is pressed.
    logic [NKEYS-1:0] k_n;
    assign k_n = ACTIVE_LOW ? ~user_key : user_key;

    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] stable_q, stable_nxt, stable_dly_q;
    logic [CW-1:0]    cnt_q   [NKEYS];
    logic [CW-1:0]    cnt_nxt [NKEYS];
    logic [NKEYS-1:0] press_q, press_nxt, mask_q, mask_nxt;
    logic [NKEYS-1:0] press_ev, wd_keys, pending;
    logic             wr_press, wr_mask, irq_nxt;

    // Only WD[NKEYS-1:0] is stored; the rest is deliberately dropped.
    logic unused_wd;
    assign unused_wd = ^WD;

    assign wd_keys  = WD[NKEYS-1:0];
    assign wr_press = WE && (addr == A_PRESS);
    assign wr_mask  = WE && (addr == A_MASK);
    assign press_ev = stable_q & ~stable_dly_q;

`ifdef USERKEY_RELEASE_EN
    logic [NKEYS-1:0] rel_q, rel_nxt, rel_ev;
    logic             wr_rel;
    assign wr_rel = WE && (addr == A_RELEASE);
    assign rel_ev = ~stable_q & stable_dly_q;
    // Set wins over a same-cycle W1C clear.
    assign rel_nxt = (rel_q & ~(wr_rel ? wd_keys : '0)) | rel_ev;
    assign pending = press_q | rel_q;
`else
    assign pending = press_q;
`endif

    // Per-key debounce: a disagreement must persist DB_CYCLES cycles to be accepted.
    always_comb begin
        stable_nxt = stable_q;
        for (int i = 0; i < int'(NKEYS); i++) begin
            cnt_nxt[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_nxt[i] = sync2_q[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Sticky press (set wins over W1C), mask and interrupt next-state.
    always_comb begin
        press_nxt = (press_q & ~(wr_press ? wd_keys : '0)) | press_ev;
        mask_nxt  = wr_mask ? wd_keys : mask_q;
        irq_nxt   = |(pending & mask_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            press_q      <= '0;
            mask_q       <= '0;
            irq          <= 1'b0;
            for (int i = 0; i < int'(NKEYS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= k_n;
            sync2_q      <= sync1_q;
            stable_q     <= stable_nxt;
            stable_dly_q <= stable_q;
            press_q      <= press_nxt;
            mask_q       <= mask_nxt;
            irq          <= irq_nxt;
            for (int i = 0; i < int'(NKEYS); i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef USERKEY_RELEASE_EN
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rel_q <= '0;
        end else begin
            rel_q <= rel_nxt;
        end
    end
`endif

    // Read mux; held at 0 while reset is asserted.
    always_comb begin
        RD = '0;
        if (sys_rstn) begin
            case (addr)
                A_LEVEL:   RD = 32'(stable_q);
                A_PRESS:   RD = 32'(press_q);
                A_MASK:    RD = 32'(mask_q);
`ifdef USERKEY_RELEASE_EN
                A_RELEASE: RD = 32'(rel_q);
`else
                A_RELEASE: RD = '0;
`endif
                default:   RD = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_driver_userkey_db.sv
// Directed self-checking bench for driver_userkey_db (NKEYS=8, DB_CYCLES=4,
// ACTIVE_LOW=1). Inputs change and outputs are sampled 1+ time units after
// the rising edge; "edge N" counts rising edges after an input change.

module tb_driver_userkey_db;

    logic        sys_clk = 1'b0;
    logic        sys_rstn;
    logic [7:0]  user_key;
    logic [1:0]  addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    driver_userkey_db #(
        .NKEYS      (8),
        .DB_CYCLES  (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .user_key (user_key),
        .addr     (addr),
        .WE       (WE),
        .WD       (WD),
        .RD       (RD),
        .irq      (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, RD, exp);
    endtask

    // Drive one write cycle; returns 1 time unit after the capturing edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        WD   = d;
        WE   = 1'b1;
        @(posedge sys_clk);
        #1;
        WE   = 1'b0;
        WD   = '0;
    endtask

    initial begin
        sys_rstn = 1'b1;
        user_key = 8'hFF;
        addr     = 2'd0;
        WE       = 1'b0;
        WD       = '0;

        // Asynchronous reset asserted mid-cycle.
        #7;
        sys_rstn = 1'b0;
        #1;
        chk("rst_irq", 32'(irq), 32'h0);
        chk_rd("rst_rd0", 2'd0, 32'h0);
        chk_rd("rst_rd1", 2'd1, 32'h0);
        chk_rd("rst_rd2", 2'd2, 32'h0);
        chk_rd("rst_rd3", 2'd3, 32'h0);
        @(posedge sys_clk);
        #1;
        sys_rstn = 1'b1;
        tick(1);
        chk_rd("post_rst_level", 2'd0, 32'h0);
        chk_rd("post_rst_press", 2'd1, 32'h0);
        chk_rd("post_rst_mask",  2'd2, 32'h0);
        chk_rd("post_rst_rel",   2'd3, 32'h0);
        chk("post_rst_irq", 32'(irq), 32'h0);

        // Glitch of 3 cycles on key0 must be rejected.
        user_key = 8'hFE;
        tick(3);
        user_key = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_rd("glitch_level", 2'd0, 32'h0);
        end
        chk_rd("glitch_press", 2'd1, 32'h0);

        // Held press on key0: LEVEL after edge 6, PRESS after edge 7.
        user_key = 8'hFE;
        tick(5);
        chk_rd("acc_level_e5", 2'd0, 32'h0);
        tick(1);
        chk_rd("acc_level_e6", 2'd0, 32'h1);
        chk_rd("acc_press_e6", 2'd1, 32'h0);
        tick(1);
        chk_rd("acc_press_e7", 2'd1, 32'h1);
        chk("acc_irq_unmasked", 32'(irq), 32'h0);

        // Writes to LEVEL are ignored.
        wr(2'd0, 32'h0);
        chk_rd("level_ro", 2'd0, 32'h1);

        // Mask: upper bits dropped, irq one cycle after the write.
        wr(2'd2, 32'hFFFF_FF01);
        chk_rd("mask_rd", 2'd2, 32'h1);
        chk("irq_before", 32'(irq), 32'h0);
        tick(1);
        chk("irq_after_mask", 32'(irq), 32'h1);

        // W1C clear of PRESS drops irq on the following edge.
        wr(2'd1, 32'h1);
        chk_rd("w1c_press", 2'd1, 32'h0);
        chk("irq_lag", 32'(irq), 32'h1);
        tick(1);
        chk("irq_cleared", 32'(irq), 32'h0);

        // Set wins: W1C of bit2 lands on the same edge as key2's press event.
        user_key = 8'hFA;
        tick(6);
        chk_rd("sw_level", 2'd0, 32'h5);
        wr(2'd1, 32'h4);
        chk_rd("set_wins", 2'd1, 32'h4);
        tick(1);
        chk("sw_irq_masked", 32'(irq), 32'h0);
        wr(2'd1, 32'h4);
        chk_rd("sw_clear", 2'd1, 32'h0);

        // Reset during key3 debounce; keys 0,2,3 held through reset.
        user_key = 8'hF2;
        tick(3);
        sys_rstn = 1'b0;
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk_rd("mid_rst_rd0", 2'd0, 32'h0);
        chk_rd("mid_rst_rd1", 2'd1, 32'h0);
        chk_rd("mid_rst_rd2", 2'd2, 32'h0);
        @(posedge sys_clk);
        #1;
        sys_rstn = 1'b1;
        tick(5);
        chk_rd("rdb_level_e5", 2'd0, 32'h0);
        tick(1);
        chk_rd("rdb_level_e6", 2'd0, 32'h0D);
        chk_rd("rdb_press_e6", 2'd1, 32'h0);
        tick(1);
        chk_rd("rdb_press_e7", 2'd1, 32'h0D);
        chk_rd("rdb_mask", 2'd2, 32'h0);

        // Prepare for release: clear presses, unmask key0.
        wr(2'd1, 32'hFF);
        chk_rd("rel_prep_press", 2'd1, 32'h0);
        wr(2'd2, 32'h1);
        tick(1);
        chk("rel_prep_irq", 32'(irq), 32'h0);

        // Release key0.
        user_key = 8'hF3;
        tick(5);
        chk_rd("rel_level_e5", 2'd0, 32'h0D);
        tick(1);
        chk_rd("rel_level_e6", 2'd0, 32'h0C);
        chk_rd("rel_reg_e6", 2'd3, 32'h0);
        tick(1);
        chk_rd("rel_press_e7", 2'd1, 32'h0);
`ifdef USERKEY_RELEASE_EN
        chk_rd("rel_reg_e7", 2'd3, 32'h1);
        tick(1);
        chk("rel_irq", 32'(irq), 32'h1);
        wr(2'd3, 32'h1);
        chk_rd("rel_w1c", 2'd3, 32'h0);
`else
        chk_rd("rsvd_e7", 2'd3, 32'h0);
        tick(1);
        chk("rel_no_irq", 32'(irq), 32'h0);
        wr(2'd3, 32'hFFFF_FFFF);
        chk_rd("rsvd_wr", 2'd3, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
